// File: rtl/vr_commit_eng.sv
// vr_commit_eng: consumes header-stripped Commit messages, validates them
// against the local view and prepared log tail, and advances the replica
// commit point one log-apply request at a time.
//
// Handshakes: every *_val/*_rdy pair transfers on a rising clock edge where
// both are high. A producer holds val and its payload stable until that edge
// and never makes val depend on rdy. A consumer may drive rdy freely.

package vr_commit_pkg;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;
endpackage

module vr_commit_eng #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
  parameter int OPNUM_W        = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          manage_commit_msg_val,
  input  vr_commit_pkg::udp_info        manage_commit_pkt_info,
  output logic                          commit_manage_msg_rdy,
  input  logic                          manage_commit_req_val,
  input  logic [NOC_DATA_W-1:0]         manage_commit_req,
  input  logic                          manage_commit_req_last,
  input  logic [NOC_PADBYTES_W-1:0]     manage_commit_req_padbytes,
  output logic                          commit_manage_req_rdy,
  input  logic [OPNUM_W-1:0]            cur_view,
  input  logic                          vr_normal,
  input  logic [OPNUM_W-1:0]            log_tail_opnum,
  output logic                          commit_apply_val,
  output logic [OPNUM_W-1:0]            commit_apply_opnum,
  input  logic                          apply_commit_rdy,
  output logic [OPNUM_W-1:0]            commit_point,
  output logic                          commit_eng_rdy,
  output logic [2:0]                    o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_APPLY = 3'd4
  } state_t;

  // A first beat must carry at least the 16 bytes of view + commit opnum.
  localparam logic [NOC_PADBYTES_W-1:0] PAD_MAX = NOC_PADBYTES_W'(NOC_PADBYTES - 16);

  state_t                 r_state;
  state_t                 w_next;
  vr_commit_pkg::udp_info r_pkt_info;
  logic [OPNUM_W-1:0]     r_view;
  logic [OPNUM_W-1:0]     r_commit_opnum;
  logic                   r_malformed;
  logic [OPNUM_W-1:0]     r_target;
  logic [OPNUM_W-1:0]     r_apply_ctr;
  logic [OPNUM_W-1:0]     r_commit_point;
  logic [OPNUM_W-1:0]     w_target;
  logic                   w_drop;
  logic                   w_req_hs;
  logic                   w_apply_hs;

  assign w_req_hs   = manage_commit_req_val & commit_manage_req_rdy;
  assign w_apply_hs = commit_apply_val & apply_commit_rdy;

  // Never commit past what has actually been prepared locally.
  assign w_target = (r_commit_opnum < log_tail_opnum) ? r_commit_opnum : log_tail_opnum;
  assign w_drop   = r_malformed | ~vr_normal | (r_view != cur_view) |
                    (w_target <= r_commit_point);

  assign commit_apply_opnum = r_apply_ctr;
  assign commit_point       = r_commit_point;
  assign o_dbg_state        = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next                = r_state;
    commit_manage_msg_rdy = 1'b0;
    commit_manage_req_rdy = 1'b0;
    commit_apply_val      = 1'b0;
    commit_eng_rdy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        commit_manage_msg_rdy = 1'b1;
        commit_eng_rdy        = 1'b1;
        if (manage_commit_msg_val) w_next = ST_HDR;
      end
      ST_HDR: begin
        commit_manage_req_rdy = 1'b1;
        if (manage_commit_req_val)
          w_next = manage_commit_req_last ? ST_CHECK : ST_DRAIN;
      end
      ST_DRAIN: begin
        commit_manage_req_rdy = 1'b1;
        if (manage_commit_req_val && manage_commit_req_last) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_next = w_drop ? ST_IDLE : ST_APPLY;
      end
      ST_APPLY: begin
        commit_apply_val = 1'b1;
        if (apply_commit_rdy && (r_apply_ctr == r_target)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Message capture, validation result and commit-point advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_info     <= '0;
      r_view         <= '0;
      r_commit_opnum <= '0;
      r_malformed    <= 1'b0;
      r_target       <= '0;
      r_apply_ctr    <= '0;
      r_commit_point <= '0;
    end else begin
      if (r_state == ST_IDLE && manage_commit_msg_val)
        r_pkt_info <= manage_commit_pkt_info;
      if (r_state == ST_HDR && w_req_hs) begin
        r_view         <= manage_commit_req[NOC_DATA_W-1 -: OPNUM_W];
        r_commit_opnum <= manage_commit_req[NOC_DATA_W-OPNUM_W-1 -: OPNUM_W];
        r_malformed    <= manage_commit_req_last & (manage_commit_req_padbytes > PAD_MAX);
      end
      if (r_state == ST_CHECK && !w_drop) begin
        r_target    <= w_target;
        r_apply_ctr <= r_commit_point + 1'b1;
      end
      if (r_state == ST_APPLY && w_apply_hs) begin
        r_commit_point <= r_apply_ctr;
        r_apply_ctr    <= r_apply_ctr + 1'b1;
      end
    end
  end

endmodule

// File: doc/vr_commit_eng.md
Name: vr_commit_eng

Overview:
- Consumes Commit messages that the management dispatch stage has already stripped of the Beehive header, on the manage_commit_* meta/data handshakes.
- Validates the message against the local view and prepared log tail.
- Advances the replica commit point, issuing one log-apply request per newly committed opnum to the downstream apply/app stage.
- Reports idle on commit_eng_rdy, one input to the dispatch stage's all_eng_rdy.

Parameters:
- NOC_DATA_W, 512, data beat width in bits (≥128).
- NOC_PADBYTES, NOC_DATA_W/8, bytes per beat.
- NOC_PADBYTES_W, $clog2(NOC_PADBYTES), padbytes width.
- OPNUM_W, 64, opnum and view-number width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- manage_commit_msg_val  in  1  metadata valid.
- manage_commit_pkt_info  in  udp_info  UDP metadata; data_length excludes Beehive header.
- commit_manage_msg_rdy  out  1  metadata ready.
- manage_commit_req_val  in  1  data beat valid.
- manage_commit_req  in  NOC_DATA_W  data beat, byte 0 in MSBs.
- manage_commit_req_last  in  1  final beat.
- manage_commit_req_padbytes  in  NOC_PADBYTES_W  invalid trailing bytes on last beat.
- commit_manage_req_rdy  out  1  data ready.
- cur_view  in  OPNUM_W  replica's current view number.
- vr_normal  in  1  replica status is NORMAL.
- log_tail_opnum  in  OPNUM_W  highest prepared opnum.
- commit_apply_val  out  1  apply request valid.
- commit_apply_opnum  out  OPNUM_W  opnum to apply.
- apply_commit_rdy  in  1  apply request ready.
- commit_point  out  OPNUM_W  current commit point (registered).
- commit_eng_rdy  out  1  engine idle.

Behaviour:
- Reset values: commit_point=0, state IDLE.
- Reset outputs: commit_manage_msg_rdy=1, commit_manage_req_rdy=0, commit_apply_val=0, commit_eng_rdy=1.
- Reset is asynchronous and may assert mid-message. On reset the partial message is abandoned; no apply is issued for it and commit_point returns to 0.
- Payload format, first beat: view = bits [NOC_DATA_W-1 -: 64]; commit_opnum = next 64 bits down. Further beats are ignored and drained.
- IDLE:
  - msg_rdy=1 and eng_rdy=1; req_rdy=0.
  - On msg_val, latch pkt_info and go to HDR. commit_eng_rdy drops the following cycle.
- HDR:
  - req_rdy=1. On a data handshake, latch view and commit_opnum.
  - malformed = last & (padbytes > NOC_PADBYTES-16).
  - If last, go to CHECK; otherwise go to DRAIN.
- DRAIN: req_rdy=1; go to CHECK on a handshake with last.
- CHECK (one cycle, no handshakes):
  - target = min(commit_opnum, log_tail_opnum).
  - Drop, returning to IDLE, if any of the following hold: malformed, !vr_normal, view != cur_view, or target <= commit_point.
  - Otherwise set apply_ctr = commit_point+1 and go to APPLY.
- APPLY:
  - commit_apply_val=1, commit_apply_opnum=apply_ctr.
  - On apply_commit_rdy: commit_point<=apply_ctr and apply_ctr++. If apply_ctr==target, go to IDLE.
  - commit_point therefore advances one per accepted apply and is never ahead of an issued apply.
  - val must stay asserted and opnum stable until rdy.
- Comparisons are unsigned OPNUM_W-bit; no wrap handling (64-bit opnums never wrap).
- cur_view, vr_normal, and log_tail_opnum are sampled only in CHECK. Changes during APPLY do not abort the burst.
- Throughput: one data beat per cycle. Minimum latency from meta accept to first apply_val is 3 cycles: HDR beat, CHECK, APPLY.
- Metadata for the next message is not accepted until the engine returns to IDLE.

Test Plan:
- Reset, cur_view=3, vr_normal=1, log_tail=10; send a one-beat Commit view=3 commit=5 with apply_rdy=1. Expect applies for opnums 1..5 on consecutive cycles, then commit_point=5 and commit_eng_rdy=1.
- With commit_point=5, send view=2 commit=8. Expect the message drained, no apply, commit_point stays 5.
- With commit_point=5 and log_tail=7, send view=3 commit=9. Expect applies for 6 and 7 only, then commit_point=7.
- Three-beat message with req_val toggling every other cycle and apply_rdy held low for 4 cycles. Expect all beats drained, commit_apply_opnum held stable during the stall, and correct final commit_point.
- Single beat with padbytes=NOC_PADBYTES-8. Expect it dropped as malformed; duplicate commit=commit_point is also dropped.
- Assert rst_n low in the middle of APPLY. Expect outputs at their reset values immediately, and the next Commit processed from commit_point=0.
